spi_xfer_arbiter: RTL

Round-robin scheduler that shares one `spi_module` master among `N_REQ` byte-transfer requesters. It holds the SPI configuration word static and waits out a settle period after reset. It then grants one requester at a time, launches the transfer with a `trans_en` pulse, and tracks completion through the SS line. Read data returns to the granted requester with a one-cycle valid pulse, and an optional watchdog aborts transfers that stall.

---
 rtl/spi_pkg.sv | 41 ++++
 rtl/spi_xfer_arbiter_rr_pick.sv | 30 +++
 rtl/spi_xfer_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM states and SPI CTRL1 layout for the SPI transfer arbiter
package spi_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_RESP    = 3'd5,
        ST_GAP     = 3'd6
    } arb_state_t;

    localparam int CTRL1_IE   = 7;
    localparam int CTRL1_SPE  = 6;
    localparam int CTRL1_MSTR = 4;
    localparam int CTRL1_CPOL = 3;
    localparam int CTRL1_CPHA = 2;
    localparam int CTRL1_SSOE = 1;
    localparam int CTRL1_MSBF = 0;

    function automatic logic [7:0] ctrl1_word(input logic ie, input logic spe, input logic mstr,
                                              input logic cpol, input logic cpha, input logic ssoe,
                                              input logic msbf);
        logic [7:0] w;
        w             = '0;
        w[CTRL1_IE]   = ie;
        w[CTRL1_SPE]  = spe;
        w[CTRL1_MSTR] = mstr;
        w[CTRL1_CPOL] = cpol;
        w[CTRL1_CPHA] = cpha;
        w[CTRL1_SSOE] = ssoe;
        w[CTRL1_MSBF] = msbf;
        return w;
    endfunction

    // Enabled master, CPHA=1, SS driven by the core, MSB first; CTRL2/STATUS 0, BAUD 0x11.
    localparam logic [31:0] CFG_WORD_DEFAULT =
        {ctrl1_word(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1), 8'h00, 8'h00, 8'h11};

endpackage

// File: rtl/spi_xfer_arbiter_rr_pick.sv
// rtl/spi_xfer_arbiter_rr_pick.sv - combinational round-robin pick starting after ptr
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] idx
);

    logic found;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        // The current holder is visited last so it becomes lowest priority.
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                win[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin sharing of one SPI master; SPI_ARB_TIMEOUT_EN adds a stall watchdog
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int          N_REQ       = 4,
    parameter logic [31:0] CFG_WORD    = CFG_WORD_DEFAULT,
    parameter int          SETTLE_CYC  = 8,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic [31:0]        spi_data_config,
    output logic               spi_trans_en,
    output logic [7:0]         spi_i_data,
    input  logic [7:0]         spi_o_data,
    input  logic               spi_ss
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || SETTLE_CYC < 2 || SETTLE_CYC > 255 ||
        TIMEOUT_CYC < 16 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("spi_xfer_arbiter: parameter out of range");
    end

    arb_state_t       state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] win;
    logic [IDX_W-1:0] win_idx;
    logic             ss_meta, ss_sync;
    logic             grant_go;
    logic             capture;
    logic             timeout_go;
    logic             wd_hit;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .win (win),
        .idx (win_idx)
    );

    assign spi_data_config = CFG_WORD;
    assign busy            = (state != ST_IDLE);
    assign spi_trans_en    = (state == ST_LAUNCH);
    assign rsp_valid       = (state == ST_RESP) ? (N_REQ'(1) << ptr) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_SETTLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        grant_go   = 1'b0;
        capture    = 1'b0;
        timeout_go = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (cnt == 8'(SETTLE_CYC - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_IDLE: begin
                if (|req) begin
                    grant_go  = 1'b1;
                    state_nxt = ST_LAUNCH;
                    cnt_nxt   = '0;
                end
            end
            ST_LAUNCH: begin
                if (cnt == 8'd1) begin
                    state_nxt = ST_WAIT_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_WAIT_LO: begin
                if (wd_hit) begin
                    timeout_go = 1'b1;
                    state_nxt  = ST_RESP;
                end else if (!ss_sync) begin
                    state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (ss_sync) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (wd_hit) begin
                    timeout_go = 1'b1;
                    state_nxt  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_GAP;
                cnt_nxt   = '0;
            end
            ST_GAP: begin
                if (cnt == 8'd1) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= IDX_W'(N_REQ - 1);
            gnt        <= '0;
            spi_i_data <= '0;
            rsp_data   <= '0;
            ss_meta    <= 1'b1;
            ss_sync    <= 1'b1;
        end else begin
            ss_meta <= spi_ss;
            ss_sync <= ss_meta;
            gnt     <= grant_go ? win : '0;
            if (grant_go) begin
                ptr        <= win_idx;
                spi_i_data <= req_data[8*win_idx +: 8];
            end
            if (capture) begin
                rsp_data <= spi_o_data;
            end else if (timeout_go) begin
                rsp_data <= 8'h00;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Counts from LAUNCH entry; cleared by the grant that enters LAUNCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (grant_go) begin
                wd_cnt <= '0;
            end else if (state == ST_LAUNCH || state == ST_WAIT_LO || state == ST_WAIT_HI) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (capture) begin
                rsp_err <= 1'b0;
            end else if (timeout_go) begin
                rsp_err <= 1'b1;
            end
        end
    end

    assign wd_hit = (wd_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign wd_hit  = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule
